// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings and default vectors.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StHold  = 3'd2,
        StDrain = 3'd3,
        StHalt  = 3'd4
    } fetch_state_e;

    localparam logic [15:0] BootAddrDefault  = 16'h0000;
    localparam logic [15:0] IrqVectorDefault = 16'h0010;

endpackage

// File: rtl/pc_fetch_ctrl_pc.sv
// 16-bit program counter with synchronous active-high reset, load and increment.
module pc_fetch_ctrl_pc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [15:0] in_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;

    // Load has precedence; the controller never asserts both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= 16'h0000;
        end else if (load_i) begin
            pc_q <= in_i;
        end else if (inc_i) begin
            pc_q <= pc_q + 16'd1;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC, issues req/ack fetches, hands instructions to decode.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] BOOT_ADDR  = BootAddrDefault,
    parameter logic [15:0] IRQ_VECTOR = IrqVectorDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        jump_i,
    input  logic [15:0] jump_target_i,
    input  logic        irq_i,
    input  logic        irq_en_i,
    output logic        irq_ack_o,
    output logic [15:0] epc_o,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [15:0] pc_o,
    output logic        halted_o
);

    fetch_state_e state_q, state_d;
    logic [15:0]  addr_q, addr_d;
    logic [15:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [15:0]  epc_q, epc_d;
    logic         irq_ack_q, irq_ack_d;
    logic         halt_pend_q, halt_pend_d;

    logic         pc_load, pc_inc;
    logic [15:0]  pc_in, pc;
    logic         irq_take, halt_now;

    pc_fetch_ctrl_pc u_pc (
        .clk_i  (clk_i),
        .rst_i  (~rst_ni),
        .load_i (pc_load),
        .inc_i  (pc_inc),
        .in_i   (pc_in),
        .pc_o   (pc)
    );

    assign irq_take = irq_i & irq_en_i;
    // A halt arriving in the boundary cycle itself counts as pending.
    assign halt_now = halt_pend_q | (halt_i & (state_q inside {StFetch, StDrain, StHold}));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        epc_d       = epc_q;
        irq_ack_d   = 1'b0;
        halt_pend_d = halt_now;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_in       = jump_target_i;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pc_load = 1'b1;
                    pc_in   = BOOT_ADDR;
                    addr_d  = BOOT_ADDR;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (jump_i) begin
                    pc_load = 1'b1;
                    if (imem_ack_i) begin
                        addr_d = jump_target_i;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    valid_d = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StHold;
                end
            end
            StDrain: begin
                // Request stays at the old address until the memory answers.
                if (jump_i) begin
                    pc_load = 1'b1;
                end
                if (imem_ack_i) begin
                    addr_d  = jump_i ? jump_target_i : pc;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (jump_i) begin
                    valid_d = 1'b0;
                    pc_load = 1'b1;
                    addr_d  = jump_target_i;
                    state_d = StFetch;
                end else if (instr_ready_i) begin
                    valid_d = 1'b0;
                    if (irq_take) begin
                        epc_d     = pc;
                        pc_load   = 1'b1;
                        pc_in     = IRQ_VECTOR;
                        addr_d    = IRQ_VECTOR;
                        irq_ack_d = 1'b1;
                        state_d   = StFetch;
                    end else if (halt_now) begin
                        halt_pend_d = 1'b0;
                        state_d     = StHalt;
                    end else begin
                        addr_d  = pc;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                if (irq_take) begin
                    epc_d     = pc;
                    pc_load   = 1'b1;
                    pc_in     = IRQ_VECTOR;
                    addr_d    = IRQ_VECTOR;
                    irq_ack_d = 1'b1;
                    state_d   = StFetch;
                end else if (start_i) begin
                    addr_d  = pc;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= 16'h0000;
            instr_q     <= 16'h0000;
            valid_q     <= 1'b0;
            epc_q       <= 16'h0000;
            irq_ack_q   <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            epc_q       <= epc_d;
            irq_ack_q   <= irq_ack_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_req_o    = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr_o   = addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign epc_o         = epc_q;
    assign irq_ack_o     = irq_ack_q;
    assign pc_o          = pc;
    assign halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: boot, latency, jump/drain, stall, interrupt, halt, wrap, reset.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, jump, irq, irq_en, imem_ack, instr_ready;
    logic [15:0] jump_target, imem_data;
    logic        irq_ack, imem_req, instr_valid, halted;
    logic [15:0] epc, imem_addr, instr, pc;

    int passed = 0;
    int total  = 0;

    pc_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .halt_i        (halt),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .irq_i         (irq),
        .irq_en_i      (irq_en),
        .irq_ack_o     (irq_ack),
        .epc_o         (epc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .pc_o          (pc),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; jump = 1'b0; irq = 1'b0; irq_en = 1'b0;
        imem_ack = 1'b0; instr_ready = 1'b0; jump_target = 16'h0000; imem_data = 16'h0000;

        // Reset
        step(); step();
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'h0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_epc", epc, 16'h0000);
        chk("rst_irq_ack", 16'(irq_ack), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);

        // 1: boot and three back-to-back fetches
        rst_n = 1'b1; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t1_req", 16'(imem_req), 16'h1);
            chk("t1_addr", imem_addr, 16'(i));
            imem_ack = 1'b1; imem_data = 16'h1000 + 16'(i); step(); imem_ack = 1'b0;
            chk("t1_valid", 16'(instr_valid), 16'h1);
            chk("t1_instr", instr, 16'h1000 + 16'(i));
            chk("t1_pc", pc, 16'(i + 1));
            chk("t1_hold_req", 16'(imem_req), 16'h0);
            instr_ready = 1'b1; step(); instr_ready = 1'b0;
        end

        // 2: three-cycle ack latency
        for (int k = 0; k < 3; k++) begin
            chk("t2_req", 16'(imem_req), 16'h1);
            chk("t2_addr", imem_addr, 16'h0003);
            step();
        end
        imem_ack = 1'b1; imem_data = 16'hA5A5; step(); imem_ack = 1'b0;
        chk("t2_instr", instr, 16'hA5A5);
        chk("t2_valid", 16'(instr_valid), 16'h1);
        chk("t2_pc", pc, 16'h0004);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t2_next_addr", imem_addr, 16'h0004);

        // 3: jump before ack -> drain
        jump = 1'b1; jump_target = 16'h0100; step(); jump = 1'b0;
        chk("t3_drain_req", 16'(imem_req), 16'h1);
        chk("t3_drain_addr", imem_addr, 16'h0004);
        chk("t3_pc", pc, 16'h0100);
        imem_ack = 1'b1; imem_data = 16'hDEAD; step(); imem_ack = 1'b0;
        chk("t3_stale_valid", 16'(instr_valid), 16'h0);
        chk("t3_req", 16'(imem_req), 16'h1);
        chk("t3_addr", imem_addr, 16'h0100);
        imem_ack = 1'b1; imem_data = 16'h1111; step(); imem_ack = 1'b0;
        chk("t3_instr", instr, 16'h1111);
        chk("t3_pc_inc", pc, 16'h0101);

        // 4: decode stall
        for (int k = 0; k < 4; k++) begin
            chk("t4_instr", instr, 16'h1111);
            chk("t4_valid", 16'(instr_valid), 16'h1);
            chk("t4_no_req", 16'(imem_req), 16'h0);
            step();
        end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t4_req", 16'(imem_req), 16'h1);
        chk("t4_addr", imem_addr, 16'h0101);
        chk("t4_valid_drop", 16'(instr_valid), 16'h0);

        // 5: interrupt at accept with PC=0005
        jump = 1'b1; jump_target = 16'h0004; step(); jump = 1'b0;
        imem_ack = 1'b1; imem_data = 16'h0BAD; step(); imem_ack = 1'b0;
        chk("t5_refetch_addr", imem_addr, 16'h0004);
        imem_ack = 1'b1; imem_data = 16'h2222; step(); imem_ack = 1'b0;
        chk("t5_pc", pc, 16'h0005);
        irq = 1'b1; irq_en = 1'b1; instr_ready = 1'b1; step();
        irq = 1'b0; instr_ready = 1'b0;
        chk("t5_irq_ack", 16'(irq_ack), 16'h1);
        chk("t5_epc", epc, 16'h0005);
        chk("t5_addr", imem_addr, 16'h0010);
        chk("t5_pc_vec", pc, 16'h0010);
        step();
        chk("t5_irq_ack_pulse", 16'(irq_ack), 16'h0);
        chk("t5_addr_hold", imem_addr, 16'h0010);

        // 6a: halt pulse mid-fetch, halt at boundary, resume
        halt = 1'b1; step(); halt = 1'b0;
        imem_ack = 1'b1; imem_data = 16'h3333; step(); imem_ack = 1'b0;
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t6_halted", 16'(halted), 16'h1);
        chk("t6_halt_req", 16'(imem_req), 16'h0);
        chk("t6_halt_pc", pc, 16'h0011);
        jump = 1'b1; jump_target = 16'h7777; step(); jump = 1'b0;
        chk("t6_halt_jump_ign", pc, 16'h0011);
        chk("t6_still_halted", 16'(halted), 16'h1);
        start = 1'b1; step(); start = 1'b0;
        chk("t6_resume_halted", 16'(halted), 16'h0);
        chk("t6_resume_addr", imem_addr, 16'h0011);

        // 6b: PC wrap
        jump = 1'b1; jump_target = 16'hFFFF; step(); jump = 1'b0;
        imem_ack = 1'b1; step();
        chk("t6_ffff_addr", imem_addr, 16'hFFFF);
        imem_data = 16'h4444; step(); imem_ack = 1'b0;
        chk("t6_wrap_pc", pc, 16'h0000);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t6_wrap_addr", imem_addr, 16'h0000);

        // 6c: reset mid-fetch
        rst_n = 1'b0; step();
        chk("t6_rst_req", 16'(imem_req), 16'h0);
        chk("t6_rst_pc", pc, 16'h0000);
        chk("t6_rst_epc", epc, 16'h0000);
        rst_n = 1'b1; step();
        chk("t6_idle_req", 16'(imem_req), 16'h0);

        // Jump in HOLD beats accept; jump coincident with ack
        start = 1'b1; step(); start = 1'b0;
        imem_ack = 1'b1; imem_data = 16'h5555; step(); imem_ack = 1'b0;
        jump = 1'b1; jump_target = 16'h0200; instr_ready = 1'b1; step();
        jump = 1'b0; instr_ready = 1'b0;
        chk("t7_hold_jump_valid", 16'(instr_valid), 16'h0);
        chk("t7_hold_jump_addr", imem_addr, 16'h0200);
        jump = 1'b1; jump_target = 16'h0300; imem_ack = 1'b1; imem_data = 16'h6666; step();
        jump = 1'b0; imem_ack = 1'b0;
        chk("t7_ackjump_valid", 16'(instr_valid), 16'h0);
        chk("t7_ackjump_addr", imem_addr, 16'h0300);
        chk("t7_ackjump_pc", pc, 16'h0300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
